bram_bus_bridge: RTL and testbench

- Parametrised bridge between the shared 16-bit CPU memory bus (active-low strobes, bidirectional data) and one synchronous BRAM instance.
- Decodes an aligned address window and strips the window base, so the BRAM address starts at 0.
- Sequences single-cycle BRAM enables, waits a configurable BRAM read latency, then drives read data onto the shared bus until the requester releases it.
- One instance sits behind the memory router per BRAM-backed region (WRAM, HRAM, VRAM, OAM).

---
 rtl/bram_bus_bridge.sv | 145 ++++++++++++++
 tb/tb_bram_bus_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_bus_bridge.sv
// Bridge between the shared CPU memory bus and one synchronous BRAM.
// Decodes an aligned window, issues single-cycle BRAM enables, waits the BRAM
// read latency and drives read data onto the shared bus until released.
module bram_bus_bridge #(
  parameter logic [15:0] P_BASE_ADDR    = 16'hC000,
  parameter int          P_ADDR_BITS    = 13,
  parameter int          P_DATA_WIDTH   = 8,
  parameter int          P_READ_LATENCY = 1
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  input  logic [15:0]             I_ADDR,
  inout  wire  [P_DATA_WIDTH-1:0] IO_DATA,
  input  logic                    I_WE_L,
  input  logic                    I_RE_L,
  output logic                    O_HIT,
  output logic                    O_READY,
  output logic                    O_BRAM_EN,
  output logic                    O_BRAM_WE,
  output logic [P_ADDR_BITS-1:0]  O_BRAM_ADDR,
  output logic [P_DATA_WIDTH-1:0] O_BRAM_DIN,
  input  logic [P_DATA_WIDTH-1:0] I_BRAM_DOUT
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_HOLD  = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DRIVE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    out_en_q, out_en_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]              lat_cnt_q, lat_cnt_d;
  logic [15:0]             addr_q, addr_d;
  logic                    bram_en_q, bram_en_d;
  logic                    bram_we_q, bram_we_d;
  logic [P_ADDR_BITS-1:0]  bram_addr_q, bram_addr_d;
  logic [P_DATA_WIDTH-1:0] bram_din_q, bram_din_d;

  logic                    hit;
  logic                    rd_abort;
  logic [P_ADDR_BITS-1:0]  offset;

  // Window decode: the base is aligned, so only the upper bits need matching
  assign hit    = (I_ADDR[15:P_ADDR_BITS] == P_BASE_ADDR[15:P_ADDR_BITS]);
  assign offset = I_ADDR[P_ADDR_BITS-1:0];
  // A read in flight ends when the requester releases, starts a write or moves
  assign rd_abort = I_RE_L | ~I_WE_L | (I_ADDR != addr_q);

  assign O_HIT       = hit;
  assign O_READY     = out_en_q;
  assign O_BRAM_EN   = bram_en_q;
  assign O_BRAM_WE   = bram_we_q;
  assign O_BRAM_ADDR = bram_addr_q;
  assign O_BRAM_DIN  = bram_din_q;
  assign IO_DATA     = out_en_q ? data_q : {P_DATA_WIDTH{1'bz}};

  // Next-state and registered-output logic; enables default to single pulses
  always_comb begin
    state_d     = state_q;
    out_en_d    = out_en_q;
    data_d      = data_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    case (state_q)
      IDLE: begin
        out_en_d = 1'b0;
        if (hit && !I_WE_L) begin
          // Write takes priority over a simultaneous read strobe
          bram_en_d   = 1'b1;
          bram_we_d   = 1'b1;
          bram_addr_d = offset;
          bram_din_d  = IO_DATA;
          state_d     = WR_HOLD;
        end else if (hit && !I_RE_L) begin
          bram_en_d   = 1'b1;
          bram_addr_d = offset;
          addr_d      = I_ADDR;
          lat_cnt_d   = 3'(P_READ_LATENCY);
          state_d     = RD_WAIT;
        end
      end
      WR_HOLD: begin
        // One write per strobe assertion; wait for the strobe to drop
        if (I_WE_L) state_d = IDLE;
      end
      RD_WAIT: begin
        if (rd_abort) begin
          state_d = IDLE;
        end else if (lat_cnt_q == 3'd0) begin
          data_d   = I_BRAM_DOUT;
          out_en_d = 1'b1;
          state_d  = RD_DRIVE;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      RD_DRIVE: begin
        if (rd_abort) begin
          out_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        out_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q     <= IDLE;
      out_en_q    <= 1'b0;
      data_q      <= '0;
      lat_cnt_q   <= 3'd0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_en_q    <= out_en_d;
      data_q      <= data_d;
      lat_cnt_q   <= lat_cnt_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  // Address of the read in flight, used to detect the requester moving on
  always_ff @(posedge I_CLK) begin
    addr_q <= addr_d;
  end

endmodule

// File: tb/tb_bram_bus_bridge.sv
// Directed bench for bram_bus_bridge: two instances on shared stimulus, one
// with read latency 1 and one with read latency 3, each with its own BRAM model.
module tb_bram_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        we_l, re_l;
  logic        drv_en;
  logic [7:0]  drv_val;

  wire  [7:0]  io1, io3;
  assign io1 = drv_en ? drv_val : 8'bz;
  assign io3 = drv_en ? drv_val : 8'bz;

  logic        hit1, rdy1, en1, we1;
  logic [12:0] baddr1;
  logic [7:0]  din1, dout1;
  logic        hit3, rdy3, en3, we3;
  logic [12:0] baddr3;
  logic [7:0]  din3, dout3;

  logic [7:0]  mem1 [0:8191];
  logic [7:0]  mem3 [0:8191];
  logic [7:0]  p3_a, p3_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_bus_bridge #(.P_BASE_ADDR(16'hC000), .P_ADDR_BITS(13), .P_DATA_WIDTH(8),
                    .P_READ_LATENCY(1)) u_dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_ADDR(addr), .IO_DATA(io1),
    .I_WE_L(we_l), .I_RE_L(re_l), .O_HIT(hit1), .O_READY(rdy1),
    .O_BRAM_EN(en1), .O_BRAM_WE(we1), .O_BRAM_ADDR(baddr1),
    .O_BRAM_DIN(din1), .I_BRAM_DOUT(dout1));

  bram_bus_bridge #(.P_BASE_ADDR(16'hC000), .P_ADDR_BITS(13), .P_DATA_WIDTH(8),
                    .P_READ_LATENCY(3)) u_dut3 (
    .I_CLK(clk), .I_RESET(rst), .I_ADDR(addr), .IO_DATA(io3),
    .I_WE_L(we_l), .I_RE_L(re_l), .O_HIT(hit3), .O_READY(rdy3),
    .O_BRAM_EN(en3), .O_BRAM_WE(we3), .O_BRAM_ADDR(baddr3),
    .O_BRAM_DIN(din3), .I_BRAM_DOUT(dout3));

  // BRAM with one cycle clock-to-dout
  always @(posedge clk) begin
    if (en1) begin
      if (we1) mem1[baddr1] <= din1;
      else     dout1 <= mem1[baddr1];
    end
  end

  // BRAM with three cycles clock-to-dout
  always @(posedge clk) begin
    if (en3) begin
      if (we3) mem3[baddr3] <= din3;
      else     p3_a <= mem3[baddr3];
    end
    p3_b  <= p3_a;
    dout3 <= p3_b;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    we_l   = 1'b1;
    re_l   = 1'b1;
    drv_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    mem1[13'h1FFF] = 8'h3C;
    mem3[13'h1FFF] = 8'h3C;
    mem1[13'h0010] = 8'h77;
    mem3[13'h0010] = 8'h77;
    dout1 = 8'h00; dout3 = 8'h00; p3_a = 8'h00; p3_b = 8'h00;
    drv_val = 8'h00;
    addr    = 16'h0000;
    bus_idle();
    rst = 1'b1;
    #1;

    // Reset with the bus idle
    step();
    check_eq("rst_en", en1, 1'b0);
    check_eq("rst_we", we1, 1'b0);
    check_eq("rst_ready", rdy1, 1'b0);
    check_eq("rst_addr", baddr1, 13'h0);
    check_eq("rst_ready3", rdy3, 1'b0);
    rst = 1'b0;
    step();

    // Held write: exactly one pulse, later changes ignored
    addr = 16'hC123; drv_val = 8'hA5; drv_en = 1'b1; we_l = 1'b0;
    #1;
    check_eq("wr_hit", hit1, 1'b1);
    step();
    check_eq("wr_en", en1, 1'b1);
    check_eq("wr_we", we1, 1'b1);
    check_eq("wr_addr", baddr1, 13'h0123);
    check_eq("wr_din", din1, 8'hA5);
    check_eq("wr_en3", en3, 1'b1);
    addr = 16'hC124; drv_val = 8'h5A;
    step();
    check_eq("wr_hold_en1", en1, 1'b0);
    check_eq("wr_hold_we1", we1, 1'b0);
    step();
    check_eq("wr_hold_en2", en1, 1'b0);
    check_eq("wr_hold_din", din1, 8'hA5);
    bus_idle();
    step();
    check_eq("wr_rel_en", en1, 1'b0);
    we_l = 1'b0; drv_en = 1'b1;
    step();
    check_eq("wr2_en", en1, 1'b1);
    check_eq("wr2_addr", baddr1, 13'h0124);
    check_eq("wr2_din", din1, 8'h5A);
    bus_idle();
    step();

    // Read top of window, latency 1 and latency 3
    addr = 16'hDFFF; re_l = 1'b0;
    step();
    check_eq("rd_en", en1, 1'b1);
    check_eq("rd_we", we1, 1'b0);
    check_eq("rd_addr", baddr1, 13'h1FFF);
    check_eq("rd_ready_k", rdy1, 1'b0);
    step();
    check_eq("rd_en_off", en1, 1'b0);
    check_eq("rd_ready_k1", rdy1, 1'b0);
    step();
    check_eq("rd_ready_k2", rdy1, 1'b1);
    check_eq("rd_data_k2", io1, 8'h3C);
    check_eq("rd3_ready_k2", rdy3, 1'b0);
    step();
    check_eq("rd3_ready_k3", rdy3, 1'b0);
    check_eq("rd_hold", io1, 8'h3C);
    step();
    check_eq("rd3_ready_k4", rdy3, 1'b1);
    check_eq("rd3_data_k4", io3, 8'h3C);
    re_l = 1'b1;
    step();
    check_eq("rd_release", rdy1, 1'b0);
    check_eq("rd3_release", rdy3, 1'b0);
    step();

    // Just outside both ends of the window
    addr = 16'hBFFF; re_l = 1'b0;
    #1;
    check_eq("miss_lo_hit", hit1, 1'b0);
    step();
    check_eq("miss_lo_en", en1, 1'b0);
    step();
    check_eq("miss_lo_ready", rdy1, 1'b0);
    bus_idle();
    addr = 16'hE000; we_l = 1'b0; drv_val = 8'h11; drv_en = 1'b1;
    #1;
    check_eq("miss_hi_hit", hit1, 1'b0);
    step();
    check_eq("miss_hi_en", en1, 1'b0);
    check_eq("miss_hi_en3", en3, 1'b0);
    bus_idle();
    addr = 16'hC000;
    #1;
    check_eq("base_hit", hit1, 1'b1);
    step();

    // Write arriving during RD_WAIT aborts the read, then is serviced
    addr = 16'hC010; re_l = 1'b0;
    step();
    check_eq("ab_rd_en", en1, 1'b1);
    check_eq("ab_rd_addr", baddr1, 13'h0010);
    we_l = 1'b0; drv_val = 8'h99; drv_en = 1'b1;
    step();
    check_eq("ab_en_off", en1, 1'b0);
    check_eq("ab_ready", rdy1, 1'b0);
    step();
    check_eq("ab_wr_en", en1, 1'b1);
    check_eq("ab_wr_we", we1, 1'b1);
    check_eq("ab_wr_din", din1, 8'h99);
    check_eq("ab_ready2", rdy1, 1'b0);
    check_eq("ab_ready3", rdy3, 1'b0);
    bus_idle();
    step();
    check_eq("ab_after", rdy1, 1'b0);

    // Read back the written value, then reset while driving
    re_l = 1'b0;
    step();
    step();
    step();
    check_eq("rb_ready", rdy1, 1'b1);
    check_eq("rb_data", io1, 8'h99);
    rst = 1'b1;
    step();
    check_eq("rst_drive_ready", rdy1, 1'b0);
    check_eq("rst_drive_en", en1, 1'b0);
    rst = 1'b0;
    bus_idle();
    step();

    // Simultaneous strobes: only the write happens
    addr = 16'hC200; we_l = 1'b0; re_l = 1'b0; drv_val = 8'h42; drv_en = 1'b1;
    step();
    check_eq("both_en", en1, 1'b1);
    check_eq("both_we", we1, 1'b1);
    check_eq("both_addr", baddr1, 13'h0200);
    check_eq("both_din", din1, 8'h42);
    step();
    step();
    check_eq("both_ready", rdy1, 1'b0);
    check_eq("both_ready3", rdy3, 1'b0);
    bus_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
